// File: rtl/cfi_violation_responder.sv
// Turns commit-stage CFI violation flags into a single held exception request,
// stalls commit while it is serviced, and locks the core after repeated violations.
module cfi_violation_responder #(
    parameter int XLEN           = 64,
    parameter int CNT_WIDTH      = 8,
    parameter int LOCK_THRESHOLD = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [1:0]           flow_integrity_violated_i,
    input  logic                 available_i,
    input  logic [XLEN-1:0]      commit_pc_i,
    input  logic                 clear_i,
    input  logic                 cfi_ex_ready_i,
    output logic                 cfi_ex_valid_o,
    output logic [1:0]           cfi_ex_cause_o,
    output logic [XLEN-1:0]      cfi_ex_tval_o,
    output logic                 halt_commit_o,
    output logic [CNT_WIDTH-1:0] violation_count_o,
    output logic                 locked_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HALT,
        S_DRAIN,
        S_LOCKED
    } state_e;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    // One extra bit so a threshold equal to 2^CNT_WIDTH can never be reached.
    localparam logic [CNT_WIDTH:0]   LOCK_THR = (CNT_WIDTH + 1)'(LOCK_THRESHOLD);

    state_e                 state_q, state_d;
    logic                   valid_q, valid_d;
    logic [1:0]             cause_q, cause_d;
    logic [XLEN-1:0]        tval_q, tval_d;
    logic                   halt_q, halt_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   locked_q, locked_d;
    logic                   drain_q, drain_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            cause_q  <= 2'b00;
            tval_q   <= '0;
            halt_q   <= 1'b0;
            count_q  <= '0;
            locked_q <= 1'b0;
            drain_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            cause_q  <= cause_d;
            tval_q   <= tval_d;
            halt_q   <= halt_d;
            count_q  <= count_d;
            locked_q <= locked_d;
            drain_q  <= drain_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        cause_d  = cause_q;
        tval_d   = tval_q;
        halt_d   = halt_q;
        count_d  = count_q;
        locked_d = locked_q;
        drain_d  = drain_q;

        unique case (state_q)
            S_IDLE: begin
                if (available_i && (flow_integrity_violated_i != 2'b00)) begin
                    state_d = S_HALT;
                    valid_d = 1'b1;
                    halt_d  = 1'b1;
                    cause_d = flow_integrity_violated_i;
                    tval_d  = commit_pc_i;
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            S_HALT: begin
                if (valid_q && cfi_ex_ready_i) begin
                    valid_d = 1'b0;
                    if ({1'b0, count_q} >= LOCK_THR) begin
                        state_d  = S_LOCKED;
                        locked_d = 1'b1;
                    end else begin
                        state_d = S_DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                // First DRAIN cycle is unconditional; leave only once the flags are quiet.
                if (!drain_q) begin
                    drain_d = 1'b1;
                end else if (flow_integrity_violated_i == 2'b00) begin
                    state_d = S_IDLE;
                    halt_d  = 1'b0;
                end
            end
            S_LOCKED: begin
                if (clear_i) begin
                    state_d  = S_IDLE;
                    halt_d   = 1'b0;
                    locked_d = 1'b0;
                end
            end
            default: begin
                state_d  = S_IDLE;
                valid_d  = 1'b0;
                halt_d   = 1'b0;
                locked_d = 1'b0;
            end
        endcase

        // Clear wins over an increment in the same cycle.
        if (clear_i) begin
            count_d = '0;
        end
    end

    assign cfi_ex_valid_o    = valid_q;
    assign cfi_ex_cause_o    = cause_q;
    assign cfi_ex_tval_o     = tval_q;
    assign halt_commit_o     = halt_q;
    assign violation_count_o = count_q;
    assign locked_o          = locked_q;

endmodule
